// File: rtl/note_judge_if.sv
// Bundle between the note-script / key-decoder side and the note judge.
// The master side supplies the tick strobe, current lane code and key presses;
// the slave side (the judge) returns the judgement pulses and counters.
interface note_judge_if;
    // Script and player inputs
    logic        tick;
    logic [3:0]  pos_in;
    logic        key_valid;
    logic [3:0]  key_code;

    // Judgement results for the display logic
    logic        hit_perfect;
    logic        hit_good;
    logic        miss;
    logic [15:0] score;
    logic [7:0]  combo;
    logic [7:0]  max_combo;
    logic [1:0]  judge_state;

    modport master (
        output tick, pos_in, key_valid, key_code,
        input  hit_perfect, hit_good, miss, score, combo, max_combo, judge_state
    );

    modport slave (
        input  tick, pos_in, key_valid, key_code,
        output hit_perfect, hit_good, miss, score, combo, max_combo, judge_state
    );
endinterface

// File: rtl/note_judge.sv
// Note judge: follows the lane code coming out of the note script, tracks the
// age of the active note, judges key presses as PERFECT / GOOD / MISS and keeps
// score, combo and max combo. Every output is registered.
module note_judge #(
    parameter int NOTE_LEN    = 8,
    parameter int PERFECT_WIN = 2,
    parameter int PERFECT_PTS = 2,
    parameter int GOOD_PTS    = 1
) (
    input  logic         clk,
    input  logic         rst,
    note_judge_if.slave  bus
);

    localparam int AGE_W = (NOTE_LEN > 1) ? $clog2(NOTE_LEN) : 1;
    localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(NOTE_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OPEN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Codes 10..15 do not name a lane and behave exactly like "none".
    function automatic logic [3:0] lane_norm(input logic [3:0] code);
        return (code > 4'd9) ? 4'd0 : code;
    endfunction

    // Note tracking registers and their next values
    state_t           state_q, state_d;
    logic [3:0]       pos_q,   pos_d;
    logic [AGE_W-1:0] age_q,   age_d;

    // Judgement pulses and counters
    logic        hit_perfect_q, hit_perfect_d;
    logic        hit_good_q,    hit_good_d;
    logic        miss_q,        miss_d;
    logic [15:0] score_q,       score_d;
    logic [7:0]  combo_q,       combo_d;
    logic [7:0]  max_combo_q,   max_combo_d;

    // Decoded events for this cycle
    logic [3:0]  pos_n;
    logic [3:0]  key_n;
    logic        key_hit;
    logic        note_end;
    logic        note_start;
    logic        judge;
    logic        key_correct;
    logic        key_early;

    assign pos_n   = lane_norm(bus.pos_in);
    assign key_n   = lane_norm(bus.key_code);
    assign key_hit = bus.key_valid && (key_n != 4'd0);

    // A note ends when the script moves to another code, or when a held code
    // reaches the end of its slot and is re-armed as a fresh note.
    assign note_end   = (state_q != IDLE) &&
                        ((pos_n != pos_q) || (bus.tick && (age_q == AGE_LAST)));
    assign note_start = (pos_n != 4'd0) && ((state_q == IDLE) || note_end);

    // Presses are judged against the note as it stood before this edge, so a
    // press landing on the cycle the note ends still counts for that note.
    assign judge       = (state_q == OPEN) && key_hit;
    assign key_correct = (key_n == pos_q);
    assign key_early   = (int'(age_q) < PERFECT_WIN);

    // Next note state: start wins, then end, otherwise age and judge the note
    always_comb begin
        // NOTE: every signal written here gets a default before any branch so
        // no path leaves it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        pos_d   = pos_q;
        age_d   = age_q;

        if (note_start) begin
            state_d = OPEN;
            pos_d   = pos_n;
            age_d   = '0;
        end else if (note_end) begin
            // An ending note with nothing behind it goes idle even when it was
            // judged this cycle; holding it in DONE would swallow a new note
            // that reuses the same lane code right after a gap.
            state_d = IDLE;
            pos_d   = 4'd0;
            age_d   = '0;
        end else begin
            if (judge) begin
                state_d = DONE;
            end
            // Age keeps running in DONE so a held code still re-arms on time.
            if (bus.tick && (state_q != IDLE)) begin
                age_d = age_q + AGE_W'(1);
            end
        end
    end

    // Judgement pulses: at most one fires, a press outranks the end-of-note miss
    always_comb begin
        hit_perfect_d = judge && key_correct && key_early;
        hit_good_d    = judge && key_correct && !key_early;
        miss_d        = (judge && !key_correct) ||
                        ((state_q == OPEN) && note_end && !key_hit);
    end

    // Score, combo and max combo, all saturating
    always_comb begin
        logic [16:0] score_sum;

        score_sum   = {1'b0, score_q};
        score_d     = score_q;
        combo_d     = combo_q;

        if (hit_perfect_d) begin
            score_sum = {1'b0, score_q} + 17'(PERFECT_PTS);
        end else if (hit_good_d) begin
            score_sum = {1'b0, score_q} + 17'(GOOD_PTS);
        end
        score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];

        if (hit_perfect_d || hit_good_d) begin
            combo_d = (combo_q == 8'hFF) ? 8'hFF : combo_q + 8'd1;
        end else if (miss_d) begin
            combo_d = 8'd0;
        end

        max_combo_d = (combo_d > max_combo_q) ? combo_d : max_combo_q;
    end

    // State and output registers; reset abandons any note without a miss
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (rst) begin
            state_q       <= IDLE;
            pos_q         <= 4'd0;
            age_q         <= '0;
            hit_perfect_q <= 1'b0;
            hit_good_q    <= 1'b0;
            miss_q        <= 1'b0;
            score_q       <= 16'd0;
            combo_q       <= 8'd0;
            max_combo_q   <= 8'd0;
        end else begin
            state_q       <= state_d;
            pos_q         <= pos_d;
            age_q         <= age_d;
            hit_perfect_q <= hit_perfect_d;
            hit_good_q    <= hit_good_d;
            miss_q        <= miss_d;
            score_q       <= score_d;
            combo_q       <= combo_d;
            max_combo_q   <= max_combo_d;
        end
    end

    assign bus.hit_perfect = hit_perfect_q;
    assign bus.hit_good    = hit_good_q;
    assign bus.miss        = miss_q;
    assign bus.score       = score_q;
    assign bus.combo       = combo_q;
    assign bus.max_combo   = max_combo_q;
    assign bus.judge_state = state_q;

endmodule
